// File: rtl/button_step_conditioner_pkg.sv
// Shared types and constants for the button step conditioner.
// Debounce FSM state encoding, default debounce length and direction levels.
package button_step_conditioner_pkg;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t StIdle        = 2'd0;
    localparam btn_state_t StPressWait   = 2'd1;
    localparam btn_state_t StPressed     = 2'd2;
    localparam btn_state_t StReleaseWait = 2'd3;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // A button counts as held from acceptance until its release is confirmed.
    function automatic logic state_is_held(input btn_state_t s);
        return (s == StPressed) || (s == StReleaseWait);
    endfunction

endpackage

// File: rtl/button_step_conditioner_if.sv
// Button-side and counter-side signals of the step conditioner.
// master drives the raw buttons; slave is the conditioner itself.
interface button_step_conditioner_if;

    logic btn_up;
    logic btn_dn;
    logic step;
    logic updown;
    logic held_up;
    logic held_dn;

    modport master (
        output btn_up,
        output btn_dn,
        input  step,
        input  updown,
        input  held_up,
        input  held_dn
    );

    modport slave (
        input  btn_up,
        input  btn_dn,
        output step,
        output updown,
        output held_up,
        output held_dn
    );

endinterface

// File: rtl/button_step_conditioner_debounce_channel.sv
// One button channel: 2-flop synchroniser, press/release debounce FSM and,
// when BUTTON_REPEAT_EN is defined, auto-repeat while the press is held.
// o_pulse is combinational on the accepting transition so the top's register
// presents the step DEBOUNCE_CYCLES+2 edges after the raw input is sampled.
module button_step_conditioner_debounce_channel
    import button_step_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
`ifdef BUTTON_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
`ifdef BUTTON_REPEAT_EN
    input  logic i_other_idle,
    output logic o_idle,
`endif
    output logic o_pulse,
    output logic o_held
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    btn_state_t      r_state;
    btn_state_t      w_state_nxt;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_nxt;
    logic            w_press_pulse;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM next state; the counter is cleared on every state change.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_pulse = 1'b0;
        case (r_state)
            StIdle: begin
                if (r_sync2) begin
                    w_state_nxt = StPressWait;
                    w_cnt_nxt   = '0;
                end
            end
            StPressWait: begin
                if (!r_sync2) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CntLast) begin
                    w_state_nxt   = StPressed;
                    w_cnt_nxt     = '0;
                    w_press_pulse = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StPressed: begin
                if (!r_sync2) begin
                    w_state_nxt = StReleaseWait;
                    w_cnt_nxt   = '0;
                end
            end
            StReleaseWait: begin
                // Bounce back to PRESSED silently: no second step on release.
                if (r_sync2) begin
                    w_state_nxt = StPressed;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CntLast) begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FSM state and debounce counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_held = state_is_held(r_state);

`ifdef BUTTON_REPEAT_EN
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RptW   = $clog2(RptMax) + 1;
    localparam logic [RptW-1:0] RptDelayLast  = RptW'(REPEAT_DELAY - 1);
    localparam logic [RptW-1:0] RptPeriodLast = RptW'(REPEAT_PERIOD - 1);

    logic [RptW-1:0] r_rpt_cnt;
    logic [RptW-1:0] w_rpt_cnt_nxt;
    logic            r_rpt_armed;
    logic            w_rpt_armed_nxt;
    logic            w_rpt_pulse;

    // Repeat timer: runs only while staying in PRESSED with the other button idle.
    // The first interval is REPEAT_DELAY, later ones REPEAT_PERIOD.
    always_comb begin
        w_rpt_cnt_nxt   = r_rpt_cnt;
        w_rpt_armed_nxt = r_rpt_armed;
        w_rpt_pulse     = 1'b0;
        if ((r_state != StPressed) || (w_state_nxt != StPressed)) begin
            w_rpt_cnt_nxt   = '0;
            w_rpt_armed_nxt = 1'b0;
        end else if (i_other_idle) begin
            if (r_rpt_cnt == (r_rpt_armed ? RptPeriodLast : RptDelayLast)) begin
                w_rpt_pulse     = 1'b1;
                w_rpt_cnt_nxt   = '0;
                w_rpt_armed_nxt = 1'b1;
            end else begin
                w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
            end
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rpt_cnt   <= '0;
            r_rpt_armed <= 1'b0;
        end else begin
            r_rpt_cnt   <= w_rpt_cnt_nxt;
            r_rpt_armed <= w_rpt_armed_nxt;
        end
    end

    assign o_idle  = (r_state == StIdle);
    assign o_pulse = w_press_pulse | w_rpt_pulse;
`else
    assign o_pulse = w_press_pulse;
`endif

endmodule

// File: rtl/button_step_conditioner.sv
// Turns raw up/down buttons into a one-cycle counter step plus direction.
// Optional auto-repeat on a held button is enabled by defining BUTTON_REPEAT_EN.
module button_step_conditioner
    import button_step_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
`ifdef BUTTON_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    button_step_conditioner_if.slave    bus
);

    logic w_up_pulse;
    logic w_dn_pulse;
    logic r_step;
    logic r_updown;

`ifdef BUTTON_REPEAT_EN
    logic w_up_idle;
    logic w_dn_idle;
`endif

    button_step_conditioner_debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_REPEAT_EN
        ,
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_up (
        .clk          (clk),
        .reset        (reset),
        .i_btn        (bus.btn_up),
`ifdef BUTTON_REPEAT_EN
        .i_other_idle (w_dn_idle),
        .o_idle       (w_up_idle),
`endif
        .o_pulse      (w_up_pulse),
        .o_held       (bus.held_up)
    );

    button_step_conditioner_debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_REPEAT_EN
        ,
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_dn (
        .clk          (clk),
        .reset        (reset),
        .i_btn        (bus.btn_dn),
`ifdef BUTTON_REPEAT_EN
        .i_other_idle (w_up_idle),
        .o_idle       (w_dn_idle),
`endif
        .o_pulse      (w_dn_pulse),
        .o_held       (bus.held_dn)
    );

    // Combine press pulses; simultaneous up and down is a conflict and is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_step   <= 1'b0;
            r_updown <= DIR_UP;
        end else begin
            r_step <= w_up_pulse ^ w_dn_pulse;
            if (w_up_pulse && !w_dn_pulse) begin
                r_updown <= DIR_UP;
            end else if (w_dn_pulse && !w_up_pulse) begin
                r_updown <= DIR_DN;
            end
        end
    end

    assign bus.step   = r_step;
    assign bus.updown = r_updown;

endmodule

// File: tb/tb_button_step_conditioner.sv
// Directed bench for button_step_conditioner with DEBOUNCE_CYCLES=4
// (REPEAT_DELAY=8, REPEAT_PERIOD=3 when BUTTON_REPEAT_EN is defined).
// Cycle c is observed at the falling edge after rising edge c, where edge 0
// is the first edge to sample the new button pattern.
module tb_button_step_conditioner;

`ifdef BUTTON_REPEAT_EN
    localparam bit Rep = 1'b1;
`else
    localparam bit Rep = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    button_step_conditioner_if bus_if ();

    button_step_conditioner #(
        .DEBOUNCE_CYCLES (4)
`ifdef BUTTON_REPEAT_EN
        ,
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (3)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            bus_if.btn_up = c[0];
            bus_if.btn_dn = ~c[0];
            @(negedge clk);
            n_vec += 4;
            if (bus_if.step !== 1'b0) begin
                n_err++; $display("FAIL reset step c=%0d got %b want 0", c, bus_if.step);
            end
            if (bus_if.updown !== 1'b1) begin
                n_err++; $display("FAIL reset updown c=%0d got %b want 1", c, bus_if.updown);
            end
            if (bus_if.held_up !== 1'b0) begin
                n_err++; $display("FAIL reset held_up c=%0d got %b want 0", c, bus_if.held_up);
            end
            if (bus_if.held_dn !== 1'b0) begin
                n_err++; $display("FAIL reset held_dn c=%0d got %b want 0", c, bus_if.held_dn);
            end
        end
        bus_if.btn_up = 1'b0;
        bus_if.btn_dn = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_vec += 2;
            if (bus_if.step !== 1'b0) begin
                n_err++; $display("FAIL post_reset step c=%0d got %b want 0", c, bus_if.step);
            end
            if (bus_if.updown !== 1'b1) begin
                n_err++; $display("FAIL post_reset updown c=%0d got %b want 1", c, bus_if.updown);
            end
        end
    endtask

    task automatic test_single_press();
        logic es, eh;
        for (int c = 0; c < 30; c++) begin
            bus_if.btn_up = (c < 20);
            @(negedge clk);
            // FSM still sees the press at edges 20 and 21 (sync latency).
            es = (c == 6) || (Rep && c >= 14 && c < 22 && ((c - 14) % 3) == 0);
            eh = (c >= 6) && (c < 26);
            n_vec += 4;
            if (bus_if.step !== es) begin
                n_err++; $display("FAIL single_press step c=%0d got %b want %b", c, bus_if.step, es);
            end
            if (bus_if.held_up !== eh) begin
                n_err++; $display("FAIL single_press held_up c=%0d got %b want %b", c, bus_if.held_up, eh);
            end
            if (bus_if.updown !== 1'b1) begin
                n_err++; $display("FAIL single_press updown c=%0d got %b want 1", c, bus_if.updown);
            end
            if (bus_if.held_dn !== 1'b0) begin
                n_err++; $display("FAIL single_press held_dn c=%0d got %b want 0", c, bus_if.held_dn);
            end
        end
    endtask

    task automatic test_glitch_press();
        logic es, eh;
        for (int c = 0; c < 26; c++) begin
            bus_if.btn_up = (c == 2) ? 1'b0 : (c < 14);
            @(negedge clk);
            es = (c == 9);
            eh = (c >= 9) && (c < 20);
            n_vec += 3;
            if (bus_if.step !== es) begin
                n_err++; $display("FAIL glitch_press step c=%0d got %b want %b", c, bus_if.step, es);
            end
            if (bus_if.held_up !== eh) begin
                n_err++; $display("FAIL glitch_press held_up c=%0d got %b want %b", c, bus_if.held_up, eh);
            end
            if (bus_if.updown !== 1'b1) begin
                n_err++; $display("FAIL glitch_press updown c=%0d got %b want 1", c, bus_if.updown);
            end
        end
    endtask

    task automatic test_down_bounce_release();
        logic es, eh, eu;
        for (int c = 0; c < 25; c++) begin
            bus_if.btn_dn = (c < 12) || (c == 13);
            @(negedge clk);
            es = (c == 6);
            eh = (c >= 6) && (c < 20);
            eu = (c < 6);
            n_vec += 4;
            if (bus_if.step !== es) begin
                n_err++; $display("FAIL down_release step c=%0d got %b want %b", c, bus_if.step, es);
            end
            if (bus_if.held_dn !== eh) begin
                n_err++; $display("FAIL down_release held_dn c=%0d got %b want %b", c, bus_if.held_dn, eh);
            end
            if (bus_if.updown !== eu) begin
                n_err++; $display("FAIL down_release updown c=%0d got %b want %b", c, bus_if.updown, eu);
            end
            if (bus_if.held_up !== 1'b0) begin
                n_err++; $display("FAIL down_release held_up c=%0d got %b want 0", c, bus_if.held_up);
            end
        end
    endtask

    task automatic test_conflict();
        logic eh;
        for (int c = 0; c < 23; c++) begin
            bus_if.btn_up = (c < 12);
            bus_if.btn_dn = (c < 12);
            @(negedge clk);
            eh = (c >= 6) && (c < 18);
            n_vec += 4;
            if (bus_if.step !== 1'b0) begin
                n_err++; $display("FAIL conflict step c=%0d got %b want 0", c, bus_if.step);
            end
            if (bus_if.updown !== 1'b0) begin
                n_err++; $display("FAIL conflict updown c=%0d got %b want 0", c, bus_if.updown);
            end
            if (bus_if.held_up !== eh) begin
                n_err++; $display("FAIL conflict held_up c=%0d got %b want %b", c, bus_if.held_up, eh);
            end
            if (bus_if.held_dn !== eh) begin
                n_err++; $display("FAIL conflict held_dn c=%0d got %b want %b", c, bus_if.held_dn, eh);
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic es, eh, eu;
        // Reset at edge 3 (up in PRESS_WAIT); release is edge 4; hold raw through edge 33.
        for (int c = 0; c < 45; c++) begin
            reset = (c != 3);
            bus_if.btn_up = (c < 34);
            @(negedge clk);
            es = (c == 10) || (Rep && c >= 18 && c < 36 && ((c - 18) % 3) == 0);
            eh = (c >= 10) && (c < 40);
            eu = (c >= 3);
            n_vec += 3;
            if (bus_if.step !== es) begin
                n_err++; $display("FAIL reset_mid step c=%0d got %b want %b", c, bus_if.step, es);
            end
            if (bus_if.held_up !== eh) begin
                n_err++; $display("FAIL reset_mid held_up c=%0d got %b want %b", c, bus_if.held_up, eh);
            end
            if (bus_if.updown !== eu) begin
                n_err++; $display("FAIL reset_mid updown c=%0d got %b want %b", c, bus_if.updown, eu);
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bus_if.btn_up = 1'b0;
        bus_if.btn_dn = 1'b0;
        test_reset();
        test_single_press();
        test_glitch_press();
        test_down_bounce_release();
        test_conflict();
        test_reset_mid_debounce();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
